// File: rtl/rv64_div_unit_if.sv
// Handshake and operand bundle between the EX-stage pipeline and the
// iterative RV64M divide/remainder unit.
interface rv64_div_unit_if;
    logic        start;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  div_op;
    logic        flush;
    logic        busy;
    logic        res_valid;
    logic [63:0] res;

    modport master (
        output start, a, b, div_op, flush,
        input  busy, res_valid, res
    );

    modport slave (
        input  start, a, b, div_op, flush,
        output busy, res_valid, res
    );
endinterface

// File: rtl/rv64_div_unit.sv
// Iterative restoring radix-2 divider covering DIV/DIVU/REM/REMU and W forms.
// One quotient bit per cycle; divide-by-zero and signed overflow bypass CALC.
module rv64_div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    rv64_div_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              is_w_q;
    logic              is_rem_q;
    logic              neg_q_q;
    logic              neg_r_q;
    logic [XLEN-1:0]   divisor_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quot_q;
    logic [6:0]        cnt_q;
    logic [XLEN-1:0]   res_q;

    logic              op_w;
    logic              op_uns;
    logic              op_rem;
    logic [XLEN-1:0]   a_ext;
    logic [XLEN-1:0]   b_ext;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              b_zero;
    logic              ovf;
    logic              special;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     rem_shift;
    logic [XLEN:0]     trial;
    logic              q_bit;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quot_next;
    logic [XLEN-1:0]   q_fin;
    logic [XLEN-1:0]   r_fin;
    logic [XLEN-1:0]   calc_res;

    // W results are always sign-extended from bit 31, unsigned forms included.
    function automatic logic [XLEN-1:0] fmt(input logic [XLEN-1:0] val, input logic w);
        return w ? {{(XLEN-32){val[31]}}, val[31:0]} : val;
    endfunction

    // Operand preparation and special-case detection on the live inputs.
    always_comb begin
        op_w   = bus.div_op[2];
        op_rem = bus.div_op[1];
        op_uns = bus.div_op[0];
        if (op_w) begin
            a_ext = op_uns ? {32'b0, bus.a[31:0]} : {{32{bus.a[31]}}, bus.a[31:0]};
            b_ext = op_uns ? {32'b0, bus.b[31:0]} : {{32{bus.b[31]}}, bus.b[31:0]};
        end else begin
            a_ext = bus.a;
            b_ext = bus.b;
        end
        a_neg  = ~op_uns & a_ext[XLEN-1];
        b_neg  = ~op_uns & b_ext[XLEN-1];
        a_mag  = a_neg ? (~a_ext + 64'd1) : a_ext;
        b_mag  = b_neg ? (~b_ext + 64'd1) : b_ext;
        b_zero = (b_ext == '0);
        if (op_w)
            ovf = ~op_uns & (bus.a[31:0] == 32'h8000_0000) & (bus.b[31:0] == 32'hFFFF_FFFF);
        else
            ovf = ~op_uns & (bus.a == 64'h8000_0000_0000_0000) & (bus.b == 64'hFFFF_FFFF_FFFF_FFFF);
        special = b_zero | ovf;
        if (b_zero)
            special_res = op_rem ? a_ext : '1;
        else
            special_res = op_rem ? '0 : a_ext;
    end

    // One restoring shift-subtract step plus final sign fix-up and formatting.
    always_comb begin
        rem_shift = {1'b0, rem_q[XLEN-1:0], quot_q[XLEN-1]} >> 0;
        rem_shift = {rem_q, quot_q[XLEN-1]};
        trial     = rem_shift - {1'b0, divisor_q};
        q_bit     = ~trial[XLEN];
        rem_next  = q_bit ? trial[XLEN-1:0] : rem_shift[XLEN-1:0];
        quot_next = {quot_q[XLEN-2:0], q_bit};
        q_fin     = neg_q_q ? (~quot_next + 64'd1) : quot_next;
        r_fin     = neg_r_q ? (~rem_next + 64'd1) : rem_next;
        calc_res  = fmt(is_rem_q ? r_fin : q_fin, is_w_q);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == 7'd1) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.flush)
            state_d = IDLE;
    end

    // Datapath: W dividends are pre-shifted so their bit 31 enters first.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_w_q    <= 1'b0;
            is_rem_q  <= 1'b0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            divisor_q <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
        end else if (bus.flush) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        is_w_q    <= op_w;
                        is_rem_q  <= op_rem;
                        neg_q_q   <= a_neg ^ b_neg;
                        neg_r_q   <= a_neg;
                        divisor_q <= b_mag;
                        rem_q     <= '0;
                        quot_q    <= op_w ? {a_mag[31:0], 32'b0} : a_mag;
                        cnt_q     <= op_w ? 7'd32 : 7'd64;
                        if (special)
                            res_q <= fmt(special_res, op_w);
                    end
                end
                CALC: begin
                    rem_q  <= rem_next;
                    quot_q <= quot_next;
                    cnt_q  <= cnt_q - 7'd1;
                    if (cnt_q == 7'd1)
                        res_q <= calc_res;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res       = res_q;

endmodule
